// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the team-wide BCD decoder.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-BCD codes 10..15 render as 'E' so bad upstream data is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_scan_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while enabled, tick_c marks the wrap cycle.
module scan_tick_gen #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             tick_c,
  output logic [CNT_W-1:0] phase_q
);

  logic [CNT_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    tick_c  = 1'b0;
    if (en) begin
      if (phase_q == CNT_W'(DIV - 1)) begin
        phase_d = '0;
        tick_c  = 1'b1;
      end else begin
        phase_d = phase_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering.
// Optional blinking of selected digits when SEG7_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 1,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV   = 250
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       bcd_bus,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BUS_W = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEG_OFF = SEG_ACT_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic                  DP_OFF  = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic             tick_c;
  logic [CNT_W-1:0] phase_q;

  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_pend_q, load_pend_d;
  logic [BUS_W-1:0]      shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  last_slot_c, frame_wrap_c, capture_c;
  logic [NUM_DIGITS-1:0] blank_c;
  logic                  upper_zero_c;
  logic [3:0]            cur_bcd_c;
  logic                  cur_dp_c, cur_blank_c, an_on_c, dp_on_c;
  logic [NUM_DIGITS-1:0] onehot_c, an_sel_c;
  logic [6:0]            pat_c;

  scan_tick_gen #(
    .DIV   (SCAN_DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .tick_c  (tick_c),
    .phase_q (phase_q)
  );

  // Slot sequencing and frame-boundary capture of the shadow registers.
  always_comb begin
    last_slot_c  = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_wrap_c = tick_c && last_slot_c;
    capture_c    = frame_wrap_c && (load_pend_q || load);
    digit_idx_d  = digit_idx_q;
    if (tick_c) digit_idx_d = last_slot_c ? '0 : digit_idx_q + IDX_W'(1);
    frame_done_d = frame_wrap_c;
    shadow_bcd_d = capture_c ? bcd_bus : shadow_bcd_q;
    shadow_dp_d  = capture_c ? dp_in : shadow_dp_q;
    load_pend_d  = (load_pend_q || load) && !capture_c;
  end

  // Leading-zero mask: a digit blanks when it and everything above it are zero.
  always_comb begin
    upper_zero_c = 1'b1;
    blank_c      = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      upper_zero_c = upper_zero_c && (shadow_bcd_q[4*i +: 4] == 4'd0);
      blank_c[i]   = BLANK_LZ && upper_zero_c;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Blink phase toggles every BLINK_DIV frames; phase 1 means digits shown.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap_c) begin
      if (frame_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + BLINK_W'(1);
      end
    end
  end
`endif

  // Output pattern for the slot currently held in digit_idx_q.
  always_comb begin
    cur_bcd_c   = 4'd0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    onehot_c    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        cur_bcd_c   = shadow_bcd_q[4*i +: 4];
        cur_dp_c    = shadow_dp_q[i];
        cur_blank_c = blank_c[i];
        onehot_c[i] = 1'b1;
      end
    end
    pat_c   = (cur_blank_c || !en) ? SEG_BLANK : bcd_to_seg(cur_bcd_c);
    dp_on_c = en && cur_dp_c;
    an_on_c = en && (phase_q >= CNT_W'(DEAD_CYCLES));
`ifdef SEG7_BLINK_EN
    if (!blink_phase_q && |(blink_mask & onehot_c)) an_on_c = 1'b0;
`endif
    an_sel_c = an_on_c ? onehot_c : '0;
    seg_d    = SEG_ACT_LOW ? ~pat_c : pat_c;
    dp_d     = SEG_ACT_LOW ? !dp_on_c : dp_on_c;
    an_d     = AN_ACT_LOW ? ~an_sel_c : an_sel_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_idx_q  <= '0;
      frame_done_q <= 1'b0;
      load_pend_q  <= 1'b0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
`ifdef SEG7_BLINK_EN
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
`endif
    end else begin
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= frame_done_d;
      load_pend_q  <= load_pend_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
`ifdef SEG7_BLINK_EN
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule
